// File: rtl/uartrx_cfg.sv
// rtl/uartrx_cfg.sv - configurable UART receiver with majority-vote sampling and one-entry output buffer
module uartrx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int   M   = OVERSAMPLE / 2;
  localparam int   CW  = $clog2(OVERSAMPLE);
  localparam logic ODD = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               r_state, w_next;
  logic                 r_sync1, r_sync2, r_rx_d;
  logic [1:0]           r_prime;
  logic                 r_armed;
  logic [CW-1:0]        r_scnt;
  logic [3:0]           r_bidx;
  logic                 r_v0, r_v1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par, r_perr_acc, r_ferr_acc;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_dout_valid, r_parity_err, r_frame_err, r_overrun;

  logic w_start, w_mid, w_wrap, w_bit, w_done;

  // r_armed stays low until the real pin has been seen high through the synchroniser
  assign w_start = (r_state == S_IDLE) && r_armed && r_rx_d && !r_sync2;
  assign w_mid   = (r_scnt == CW'(M + 1));
  assign w_wrap  = (r_scnt == CW'(OVERSAMPLE - 1));
  assign w_bit   = (r_v0 & r_v1) | (r_v0 & r_sync2) | (r_v1 & r_sync2);
  assign w_done  = (r_state == S_STOP) && w_mid && (r_bidx == 4'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_START;
      S_START: begin
        if (w_mid && w_bit) w_next = S_IDLE;
        else if (w_wrap)    w_next = S_DATA;
      end
      S_DATA:  if (w_wrap && (r_bidx == 4'(DATA_BITS)))
                 w_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (w_wrap) w_next = S_STOP;
      S_STOP:  if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_d       <= 1'b1;
      r_prime      <= 2'b00;
      r_armed      <= 1'b0;
      r_scnt       <= '0;
      r_bidx       <= '0;
      r_v0         <= 1'b1;
      r_v1         <= 1'b1;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_perr_acc   <= 1'b0;
      r_ferr_acc   <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_d    <= r_sync2;
      r_prime   <= {r_prime[0], 1'b1};
      r_armed   <= r_armed | (r_prime[1] & r_sync2);
      r_overrun <= 1'b0;

      // The start-edge cycle is sample 0, so scnt tracks time since the edge
      if ((w_next == S_IDLE) || w_wrap) r_scnt <= '0;
      else                              r_scnt <= r_scnt + 1'b1;

      if (r_scnt == CW'(M - 1)) r_v0 <= r_sync2;
      if (r_scnt == CW'(M))     r_v1 <= r_sync2;

      if (w_start) begin
        r_bidx     <= '0;
        r_par      <= 1'b0;
        r_perr_acc <= 1'b0;
        r_ferr_acc <= 1'b0;
      end

      case (r_state)
        S_DATA: begin
          if (w_mid) begin
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_par   <= r_par ^ w_bit;
            r_bidx  <= r_bidx + 1'b1;
          end else if (w_wrap && (r_bidx == 4'(DATA_BITS))) begin
            r_bidx <= '0;
          end
        end
        S_PAR: if (w_mid) r_perr_acc <= r_par ^ w_bit ^ ODD;
        S_STOP: begin
          if (w_mid) begin
            r_bidx <= r_bidx + 1'b1;
            if (!w_bit) r_ferr_acc <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_done) begin
        if (!r_dout_valid || dout_ready) begin
          r_dout       <= r_shift;
          r_parity_err <= r_perr_acc;
          r_frame_err  <= r_ferr_acc | ~w_bit;
          r_dout_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uartrx_cfg.sv
// tb/tb_uartrx_cfg.sv - directed bench for uartrx_cfg across 8N1, 8E1, 8O1 and 7N2 formats
module tb_uartrx_cfg;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_a, rx_b, rx_c;
  logic rdy0, rdy1, rdy3;

  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic v0, v1, v2, v3, pe0, pe1, pe2, pe3, fe0, fe1, fe2, fe3;
  logic ov0, ov1, ov2, ov3, b0, b1, b2, b3;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  uartrx_cfg u0 (.clk(clk), .rst_n(rst_n), .rx(rx_a), .dout(d0), .dout_valid(v0), .dout_ready(rdy0),
                 .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0));
  uartrx_cfg #(.PARITY(1)) u1 (.clk(clk), .rst_n(rst_n), .rx(rx_b), .dout(d1), .dout_valid(v1),
                 .dout_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1));
  uartrx_cfg #(.PARITY(2)) u2 (.clk(clk), .rst_n(rst_n), .rx(rx_b), .dout(d2), .dout_valid(v2),
                 .dout_ready(rdy1), .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(b2));
  uartrx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.clk(clk), .rst_n(rst_n), .rx(rx_c), .dout(d3),
                 .dout_valid(v3), .dout_ready(rdy3), .parity_err(pe3), .frame_err(fe3), .overrun(ov3),
                 .busy(b3));

  logic [3:0] vld, bsy, ovr;
  assign vld = {v3, v2, v1, v0};
  assign bsy = {b3, b2, b1, b0};
  assign ovr = {ov3, ov2, ov1, ov0};

  int  vcnt[4];
  int  ocnt[4];
  time vrise[4];
  time brise[4];
  time bfall[4];
  logic [3:0] pv = 4'b0;
  logic [3:0] pb = 4'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i]) begin
        vcnt[i] = vcnt[i] + 1;
        if (!pv[i]) vrise[i] = $time;
      end
      if (ovr[i]) ocnt[i] = ocnt[i] + 1;
      if (bsy[i] && !pb[i]) brise[i] = $time;
      if (!bsy[i] && pb[i]) bfall[i] = $time;
      pv[i] = vld[i];
      pb[i] = bsy[i];
    end
  end

  time t0;
  int  vc, oc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // bits[0] is the start bit; each bit lasts 16 clk; pin index 'spike' is inverted for one clk
  task automatic send(input int line, input logic [15:0] bits, input int nbits, input int spike);
    logic v;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        v = bits[b];
        if (b * 16 + c == spike) v = ~v;
        if (b == 0 && c == 0) t0 = $time;
        case (line)
          0:       rx_a = v;
          1:       rx_b = v;
          default: rx_c = v;
        endcase
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      vcnt[i] = 0; ocnt[i] = 0; vrise[i] = 0; brise[i] = 0; bfall[i] = 0;
    end
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy3 = 1'b1;
    idle(3);
    chk("rst_dout", 64'(d0), 64'h0);
    chk("rst_valid", 64'(v0), 64'h0);
    chk("rst_busy", 64'(b0), 64'h0);
    chk("rst_perr", 64'(pe1), 64'h0);
    chk("rst_ferr", 64'(fe3), 64'h0);
    rst_n = 1'b1;
    idle(6);

    vc = vcnt[0];
    send(0, 16'h034A, 10, -1);
    idle(8);
    chk("a5_dout", 64'(d0), 64'hA5);
    chk("a5_valid_time", vrise[0] - t0, 64'd1560);
    chk("a5_valid_cycles", 64'(vcnt[0] - vc), 64'd1);
    chk("a5_perr", 64'(pe0), 64'h0);
    chk("a5_ferr", 64'(fe0), 64'h0);
    chk("a5_busy_rise", brise[0] - t0, 64'd30);
    chk("a5_busy_fall", bfall[0] - t0, 64'd1560);

    send(1, 16'h0678, 11, -1);
    idle(8);
    chk("even_dout", 64'(d1), 64'h3C);
    chk("even_perr", 64'(pe1), 64'h1);
    chk("even_ferr", 64'(fe1), 64'h0);
    chk("odd_dout", 64'(d2), 64'h3C);
    chk("odd_perr", 64'(pe2), 64'h0);

    vc = vcnt[0];
    @(negedge clk);
    rx_a = 1'b0;
    t0 = $time;
    idle(3);
    rx_a = 1'b1;
    idle(30);
    chk("glitch_no_word", 64'(vcnt[0] - vc), 64'd0);
    chk("glitch_busy_rise", brise[0] - t0, 64'd30);
    chk("glitch_busy_fall", bfall[0] - t0, 64'd120);

    send(0, 16'h0200, 10, 24);
    idle(8);
    chk("spike_dout", 64'(d0), 64'h00);

    rdy0 = 1'b0;
    oc = ocnt[0];
    send(0, 16'h0222, 10, -1);
    send(0, 16'h0244, 10, -1);
    idle(8);
    chk("ovr_dout", 64'(d0), 64'h11);
    chk("ovr_valid", 64'(v0), 64'h1);
    chk("ovr_pulses", 64'(ocnt[0] - oc), 64'd1);
    @(negedge clk);
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    chk("accept_valid", 64'(v0), 64'h0);
    chk("accept_dout", 64'(d0), 64'h11);
    rdy0 = 1'b1;

    send(2, 16'h01AA, 10, -1);
    @(negedge clk);
    rx_c = 1'b1;
    idle(8);
    chk("stop2_dout", 64'(d3), 64'h55);
    chk("stop2_ferr", 64'(fe3), 64'h1);
    send(2, 16'h0354, 10, -1);
    idle(8);
    chk("good7_dout", 64'(d3), 64'h2A);
    chk("good7_ferr", 64'(fe3), 64'h0);

    send(0, 16'h0078, 5, -1);
    @(negedge clk);
    chk("mid_busy", 64'(b0), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mrst_dout", 64'(d0), 64'h0);
    chk("mrst_valid", 64'(v0), 64'h0);
    chk("mrst_busy", 64'(b0), 64'h0);
    chk("mrst_ovr", 64'(ov0), 64'h0);
    rx_a = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(6);
    vc = vcnt[0];
    send(0, 16'h0302, 10, -1);
    idle(8);
    chk("post_rst_dout", 64'(d0), 64'h81);
    chk("post_rst_words", 64'(vcnt[0] - vc), 64'd1);
    chk("post_rst_time", vrise[0] - t0, 64'd1560);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
